// File: rtl/hack_isa_pkg.sv
// Hack ISA shared definitions: instruction field positions, word/address types
// and the decoded instruction view used by the CPU core.
package hack_isa_pkg;

  localparam int BIT_CI  = 15;
  localparam int BIT_A   = 12;
  localparam int COMP_HI = 11;
  localparam int COMP_LO = 6;
  localparam int DEST_A  = 5;
  localparam int DEST_D  = 4;
  localparam int DEST_M  = 3;
  localparam int J_LT    = 2;
  localparam int J_EQ    = 1;
  localparam int J_GT    = 0;

  typedef logic [15:0] hack_word_t;
  typedef logic [14:0] hack_addr_t;

  localparam logic [5:0] COMP_ZERO = 6'b101010;
  localparam logic [5:0] COMP_D    = 6'b001100;
  localparam logic [5:0] COMP_DP1  = 6'b011111;

  // Field layout mirrors the C-instruction bit order so a cast decodes it.
  typedef struct packed {
    logic       is_c;
    logic [1:0] spare;
    logic       a;
    logic [5:0] comp;
    logic       dest_a;
    logic       dest_d;
    logic       dest_m;
    logic       j_lt;
    logic       j_eq;
    logic       j_gt;
  } hack_instr_t;

  function automatic logic jump_taken(hack_instr_t i, logic zr, logic ng);
    return i.is_c & ((i.j_lt & ng) | (i.j_eq & zr) | (i.j_gt & ~zr & ~ng));
  endfunction

endpackage

// File: rtl/hack_alu.sv
// Existing Hack 16-bit ALU: optional zero/negate of each operand, add or AND,
// optional output negate, plus zero and negative flags.
module hack_alu
  import hack_isa_pkg::*;
(
  input  hack_word_t x,
  input  hack_word_t y,
  input  logic       zx,
  input  logic       nx,
  input  logic       zy,
  input  logic       ny,
  input  logic       f,
  input  logic       no,
  output hack_word_t o,
  output logic       zr,
  output logic       ng
);

  hack_word_t x_z, x_n, y_z, y_n, r;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    x_z = zx ? '0 : x;
    x_n = nx ? ~x_z : x_z;
    y_z = zy ? '0 : y;
    y_n = ny ? ~y_z : y_z;
    r   = f ? (x_n + y_n) : (x_n & y_n);
    o   = no ? ~r : r;
  end

  assign zr = (o == '0);
  assign ng = o[15];

endmodule

// File: rtl/hack_pc.sv
// Program counter: async reset, then stall hold, then jump load, else increment
// (15-bit wrap-around).
module hack_pc
  import hack_isa_pkg::*;
#(
  parameter hack_addr_t RESET_PC = 15'h0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mem_ready,
  input  logic       load,
  input  hack_addr_t load_value,
  output hack_addr_t pc
);

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (!mem_ready) begin
      pc <= pc;
    end else if (load) begin
      pc <= load_value;
    end else begin
      pc <= pc + 15'd1;
    end
  end

endmodule

// File: rtl/hack_cpu_core.sv
// Hack CPU: decodes A/C instructions, holds A and D, drives the ALU and the
// data-RAM interface, and sequences the PC through hack_pc.
module hack_cpu_core
  import hack_isa_pkg::*;
#(
  parameter hack_addr_t RESET_PC = 15'h0000
) (
  input  logic       clk,
  input  logic       reset,
  input  hack_word_t instruction,
  input  hack_word_t in_m,
  input  logic       mem_ready,
  output hack_word_t out_m,
  output logic       write_m,
  output hack_addr_t address_m,
  output hack_addr_t pc
);

  hack_instr_t ins;
  hack_word_t  a_reg;
  hack_word_t  d_reg;
  hack_word_t  alu_y;
  hack_word_t  alu_o;
  logic        alu_zr;
  logic        alu_ng;
  logic        take;

  assign ins   = hack_instr_t'(instruction);
  assign alu_y = ins.a ? in_m : a_reg;

  hack_alu u_alu (
    .x  (d_reg),
    .y  (alu_y),
    .zx (ins.comp[5]),
    .nx (ins.comp[4]),
    .zy (ins.comp[3]),
    .ny (ins.comp[2]),
    .f  (ins.comp[1]),
    .no (ins.comp[0]),
    .o  (alu_o),
    .zr (alu_zr),
    .ng (alu_ng)
  );

  assign out_m     = alu_o;
  // Reset suppresses the strobe so an aborted instruction never reaches RAM.
  assign write_m   = ins.is_c & ins.dest_m & ~reset;
  assign address_m = a_reg[14:0];
  assign take      = jump_taken(ins, alu_zr, alu_ng);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg <= '0;
      d_reg <= '0;
    end else if (mem_ready) begin
      if (!ins.is_c) begin
        a_reg <= instruction;
      end else begin
        if (ins.dest_a) a_reg <= alu_o;
        if (ins.dest_d) d_reg <= alu_o;
      end
    end
  end

  // Jump target is taken from A before this edge's write-back.
  hack_pc #(.RESET_PC(RESET_PC)) u_pc (
    .clk        (clk),
    .reset      (reset),
    .mem_ready  (mem_ready),
    .load       (take),
    .load_value (a_reg[14:0]),
    .pc         (pc)
  );

endmodule

// File: tb/tb_hack_cpu_core.sv
// Self-checking bench for hack_cpu_core: directed ISA scenarios plus random
// instruction streams checked against a mnemonic-level reference model.
module tb_hack_cpu_core;

  logic        clk;
  logic        reset;
  logic [15:0] instruction;
  logic [15:0] in_m;
  logic        mem_ready;
  logic [15:0] out_m;
  logic        write_m;
  logic [14:0] address_m;
  logic [14:0] pc;

  int checks = 0;
  int errors = 0;

  logic [15:0] a_m;
  logic [15:0] d_m;
  logic [14:0] pc_m;

  logic [5:0] legal_comp [18] = '{
    6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
    6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
    6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101};

  hack_cpu_core #(.RESET_PC(15'h0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .in_m        (in_m),
    .mem_ready   (mem_ready),
    .out_m       (out_m),
    .write_m     (write_m),
    .address_m   (address_m),
    .pc          (pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Hack comp mnemonics evaluated arithmetically (x = D, y = A or M).
  function automatic logic [15:0] ref_alu(input logic [5:0] c, input logic [15:0] x, input logic [15:0] y);
    case (c)
      6'b101010: return 16'd0;
      6'b111111: return 16'd1;
      6'b111010: return 16'hFFFF;
      6'b001100: return x;
      6'b110000: return y;
      6'b001101: return ~x;
      6'b110001: return ~y;
      6'b001111: return 16'd0 - x;
      6'b110011: return 16'd0 - y;
      6'b011111: return x + 16'd1;
      6'b110111: return y + 16'd1;
      6'b001110: return x - 16'd1;
      6'b110010: return y - 16'd1;
      6'b000010: return x + y;
      6'b010011: return x - y;
      6'b000111: return y - x;
      6'b000000: return x & y;
      6'b010101: return x | y;
      default:   return 16'hxxxx;
    endcase
  endfunction

  // Called just after a rising edge: present inputs, check outputs mid-cycle,
  // clock once, then advance the model.
  task automatic step(input logic [15:0] ins, input logic [15:0] inm, input logic rdy);
    logic [15:0] y;
    logic [15:0] o;
    logic        ci;
    logic        take;
    instruction = ins;
    in_m        = inm;
    mem_ready   = rdy;
    #3;
    ci = ins[15];
    o  = 16'd0;
    check("write_m", {31'd0, write_m}, {31'd0, ci & ins[3]});
    check("address_m", {17'd0, address_m}, {17'd0, a_m[14:0]});
    check("pc", {17'd0, pc}, {17'd0, pc_m});
    if (ci) begin
      y = ins[12] ? inm : a_m;
      o = ref_alu(ins[11:6], d_m, y);
      check("out_m", {16'd0, out_m}, {16'd0, o});
    end
    @(posedge clk);
    #1;
    if (rdy) begin
      if (!ci) begin
        a_m  = ins;
        pc_m = pc_m + 15'd1;
      end else begin
        take = (ins[2] && $signed(o) < 0) || (ins[1] && o == 16'd0) || (ins[0] && $signed(o) > 0);
        pc_m = take ? a_m[14:0] : pc_m + 15'd1;
        if (ins[5]) a_m = o;
        if (ins[4]) d_m = o;
      end
    end
  endtask

  initial begin
    logic [14:0] pc_before;
    logic [15:0] rins;
    clk = 0; reset = 1; instruction = 16'h0000; in_m = 16'h0000; mem_ready = 1;
    a_m = 0; d_m = 0; pc_m = 0;
    #1;
    check("rst_pc", {17'd0, pc}, 32'd0);
    check("rst_addr", {17'd0, address_m}, 32'd0);
    check("rst_write_m", {31'd0, write_m}, 32'd0);
    @(posedge clk); #1;
    reset = 0;

    // A load then D=A
    step(16'h0005, 16'h0000, 1);
    check("s2_a", {17'd0, address_m}, 32'd5);
    check("s2_pc1", {17'd0, pc}, 32'd1);
    step(16'hEC10, 16'h0000, 1);
    check("s2_pc2", {17'd0, pc}, 32'd2);

    // M=D+1 (write strobe and data checked inside step), then confirm D=5 via M=D
    step(16'hE7C8, 16'h0000, 1);
    check("s3_a_kept", {17'd0, address_m}, 32'd5);
    step(16'hE308, 16'h0000, 1);

    // D;JGT with D positive, zero and negative
    step(16'h0010, 16'h0000, 1);
    step(16'hE301, 16'h0000, 1);
    check("s4_jgt_pos", {17'd0, pc}, 32'h10);
    step(16'hEA90, 16'h0000, 1);
    step(16'h0010, 16'h0000, 1);
    pc_before = pc;
    step(16'hE301, 16'h0000, 1);
    check("s4_jgt_zero", {17'd0, pc}, {17'd0, pc_before + 15'd1});
    step(16'hEE90, 16'h0000, 1);
    step(16'h0010, 16'h0000, 1);
    pc_before = pc;
    step(16'hE301, 16'h0000, 1);
    check("s4_jgt_neg", {17'd0, pc}, {17'd0, pc_before + 15'd1});

    // AM=M-1;JMP jumps to the old A
    step(16'h0020, 16'h0000, 1);
    step(16'hFCAF, 16'h0003, 1);
    check("s5_pc_old_a", {17'd0, pc}, 32'h20);
    check("s5_a_new", {17'd0, address_m}, 32'd2);

    // Stall for three cycles on 0;JMP
    step(16'h0040, 16'h0000, 1);
    pc_before = pc;
    for (int i = 0; i < 3; i++) step(16'hEA87, 16'h0000, 0);
    check("s6_hold_pc", {17'd0, pc}, {17'd0, pc_before});
    step(16'hEA87, 16'h0000, 1);
    check("s6_jmp", {17'd0, pc}, 32'h40);

    // PC wrap
    step(16'h7FFF, 16'h0000, 1);
    step(16'hEA87, 16'h0000, 1);
    check("s7_pc_max", {17'd0, pc}, 32'h7FFF);
    step(16'h1234, 16'h0000, 1);
    check("s7_wrap", {17'd0, pc}, 32'd0);

    // Random instruction streams
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) < 3) begin
        rins = {1'b0, 15'($urandom)};
        if ($urandom_range(0, 7) == 0) rins[14:4] = 11'h7FF;
      end else begin
        rins = {3'b111, 1'($urandom), legal_comp[$urandom_range(0, 17)], 6'($urandom)};
      end
      step(rins, 16'($urandom), ($urandom_range(0, 4) != 0));
    end

    // Mid-run reset with pc=0x0123, A=0x55AA and D nonzero
    step(16'h0122, 16'h0000, 1);
    step(16'hEC10, 16'h0000, 1);
    step(16'hEA87, 16'h0000, 1);
    step(16'h55AA, 16'h0000, 1);
    check("s1_pre_pc", {17'd0, pc}, 32'h123);
    check("s1_pre_a", {17'd0, address_m}, 32'h55AA & 32'h7FFF);
    instruction = 16'hE308;
    mem_ready   = 1;
    #1 reset = 1;
    #1;
    check("s1_pc", {17'd0, pc}, 32'd0);
    check("s1_a", {17'd0, address_m}, 32'd0);
    check("s1_d", {16'd0, out_m}, 32'd0);
    check("s1_write_m", {31'd0, write_m}, 32'd0);
    a_m = 0; d_m = 0; pc_m = 0;
    @(posedge clk); #1;
    check("s1_held_pc", {17'd0, pc}, 32'd0);
    #1 reset = 0;
    step(16'h0007, 16'h0000, 1);
    check("s1_first_pc", {17'd0, pc}, 32'd1);
    check("s1_first_a", {17'd0, address_m}, 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
